// File: rtl/hs_link_pkg.sv
// Shared definitions for the burst handshake link: FSM state encodings and
// a width helper used for the word, receive and delay counters.
package hs_link_pkg;

    typedef enum logic [1:0] {
        M_IDLE,
        M_REQ,
        M_WAIT_LOW,
        M_FIN
    } m_state_e;

    typedef enum logic [1:0] {
        S_WAIT_REQ,
        S_DLY,
        S_ACK_HI
    } s_state_e;

    // Bits needed to hold values 0..n; never less than one bit.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/hs_burst_slave.sv
// Slave side of the 4-phase link: samples each word on req, optionally waits
// ACK_DELAY cycles, then holds ack until req drops. Keeps the running burst
// checksum, the last received word and the received-word count.
module hs_burst_slave
    import hs_link_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4,
    parameter int ACK_DELAY = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         req,
    input  logic [DATA_W-1:0]            data,
    output logic                         ack,
    output logic [DATA_W-1:0]            last_data,
    output logic [DATA_W-1:0]            checksum,
    output logic [cnt_w(BURST_LEN)-1:0]  rx_count
);

    localparam int RX_W = cnt_w(BURST_LEN);
    localparam int D_W  = cnt_w(ACK_DELAY);

    s_state_e          state_q, state_d;
    logic              ack_q, ack_d;
    logic [D_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0] last_q, last_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [RX_W-1:0]   rx_q, rx_d;

    // Next-state logic: capture on req, delay, then acknowledge until req falls.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d = state_q;
        ack_d   = ack_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        sum_d   = sum_q;
        rx_d    = rx_q;

        // A new burst restarts the accumulation; last_data is kept on purpose.
        if (clear) begin
            sum_d = '0;
            rx_d  = '0;
        end

        case (state_q)
            S_WAIT_REQ: begin
                if (req) begin
                    last_d = data;
                    sum_d  = sum_q + data;
                    rx_d   = rx_q + RX_W'(1);
                    if (ACK_DELAY == 0) begin
                        ack_d   = 1'b1;
                        state_d = S_ACK_HI;
                    end else begin
                        cnt_d   = D_W'(ACK_DELAY);
                        state_d = S_DLY;
                    end
                end
            end
            S_DLY: begin
                if (cnt_q <= D_W'(1)) begin
                    ack_d   = 1'b1;
                    state_d = S_ACK_HI;
                end else begin
                    cnt_d = cnt_q - D_W'(1);
                end
            end
            S_ACK_HI: begin
                if (!req) begin
                    ack_d   = 1'b0;
                    state_d = S_WAIT_REQ;
                end
            end
            default: state_d = S_WAIT_REQ;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (!rst) begin
            state_q <= S_WAIT_REQ;
            ack_q   <= 1'b0;
            cnt_q   <= '0;
            last_q  <= '0;
            sum_q   <= '0;
            rx_q    <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            sum_q   <= sum_d;
            rx_q    <= rx_d;
        end
    end

    assign ack       = ack_q;
    assign last_data = last_q;
    assign checksum  = sum_q;
    assign rx_count  = rx_q;

endmodule

// File: rtl/hs_burst_link.sv
// Burst handshake link: the master FSM sends BURST_LEN words START_VAL,
// START_VAL+STEP, ... over a 4-phase req/ack handshake to the internal slave.
module hs_burst_link
    import hs_link_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                BURST_LEN = 4,
    parameter logic [DATA_W-1:0] START_VAL = DATA_W'(8'hA0),
    parameter logic [DATA_W-1:0] STEP      = DATA_W'(1),
    parameter int                ACK_DELAY = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         req,
    output logic                         ack,
    output logic [DATA_W-1:0]            data,
    output logic [DATA_W-1:0]            last_data,
    output logic [DATA_W-1:0]            checksum,
    output logic [cnt_w(BURST_LEN)-1:0]  rx_count
);

    localparam int              K_W    = cnt_w(BURST_LEN);
    localparam logic [K_W-1:0]  K_LAST = K_W'(BURST_LEN - 1);

    m_state_e          state_q, state_d;
    logic              req_q, req_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [K_W-1:0]    k_q, k_d;
    logic              clear_burst;

    // Master next-state logic: one req/ack round trip per word, then a done pulse.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        data_d      = data_q;
        k_d         = k_q;
        clear_burst = 1'b0;

        case (state_q)
            M_IDLE: begin
                if (start) begin
                    req_d       = 1'b1;
                    data_d      = START_VAL;
                    busy_d      = 1'b1;
                    k_d         = '0;
                    clear_burst = 1'b1;
                    state_d     = M_REQ;
                end
            end
            M_REQ: begin
                if (ack) begin
                    req_d   = 1'b0;
                    state_d = M_WAIT_LOW;
                end
            end
            M_WAIT_LOW: begin
                if (!ack) begin
                    if (k_q != K_LAST) begin
                        k_d     = k_q + K_W'(1);
                        data_d  = data_q + STEP;
                        req_d   = 1'b1;
                        state_d = M_REQ;
                    end else begin
                        done_d  = 1'b1;
                        state_d = M_FIN;
                    end
                end
            end
            M_FIN: begin
                busy_d  = 1'b0;
                state_d = M_IDLE;
            end
            default: state_d = M_IDLE;
        endcase
    end

    // Master state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= M_IDLE;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            data_q  <= data_d;
            k_q     <= k_d;
        end
    end

    hs_burst_slave #(
        .DATA_W    (DATA_W),
        .BURST_LEN (BURST_LEN),
        .ACK_DELAY (ACK_DELAY)
    ) u_slave (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear_burst),
        .req       (req_q),
        .data      (data_q),
        .ack       (ack),
        .last_data (last_data),
        .checksum  (checksum),
        .rx_count  (rx_count)
    );

    assign req  = req_q;
    assign busy = busy_q;
    assign done = done_q;
    assign data = data_q;

endmodule

// File: tb/tb_hs_burst_link.sv
// Bench for hs_burst_link: four configurations checked cycle by cycle against
// a timing model derived from the burst period (4+ACK_DELAY) and word count.
module tb_hs_burst_link;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] start_v = '0;
    logic [3:0] rst_v   = '0;

    logic [3:0] busy_v, done_v, req_v, ack_v;
    logic [7:0] data_b [3];
    logic [7:0] last_b [3];
    logic [7:0] sum_b  [3];
    logic [2:0] rx_b   [3];
    logic [15:0] data_w16, last_w16, sum_w16;
    logic        rx_w16;

    // Configuration table mirroring the instances below.
    int cfg_d  [4] = '{0, 0, 2, 0};
    int cfg_n  [4] = '{4, 4, 4, 1};
    int cfg_w  [4] = '{8, 8, 8, 16};
    int cfg_sv [4] = '{'hA0, 'hFE, 'hA0, 'h1234};

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;
    int cur_c   = 0;
    int sel     = 0;

    logic        obs_busy, obs_done, obs_req, obs_ack;
    logic [15:0] obs_data, obs_last, obs_sum;
    logic [3:0]  obs_rx;

    hs_burst_link u_def (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .req(req_v[0]), .ack(ack_v[0]), .data(data_b[0]), .last_data(last_b[0]),
        .checksum(sum_b[0]), .rx_count(rx_b[0])
    );

    hs_burst_link #(.START_VAL(8'hFE)) u_wrap (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .req(req_v[1]), .ack(ack_v[1]), .data(data_b[1]), .last_data(last_b[1]),
        .checksum(sum_b[1]), .rx_count(rx_b[1])
    );

    hs_burst_link #(.ACK_DELAY(2)) u_dly (
        .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .req(req_v[2]), .ack(ack_v[2]), .data(data_b[2]), .last_data(last_b[2]),
        .checksum(sum_b[2]), .rx_count(rx_b[2])
    );

    hs_burst_link #(.DATA_W(16), .BURST_LEN(1), .START_VAL(16'h1234), .STEP(16'd1)) u_w16 (
        .clk(clk), .rst(rst_v[3]), .start(start_v[3]), .busy(busy_v[3]), .done(done_v[3]),
        .req(req_v[3]), .ack(ack_v[3]), .data(data_w16), .last_data(last_w16),
        .checksum(sum_w16), .rx_count(rx_w16)
    );

    // Route the selected instance onto one common, zero-extended view.
    always_comb begin
        obs_busy = busy_v[sel];
        obs_done = done_v[sel];
        obs_req  = req_v[sel];
        obs_ack  = ack_v[sel];
        if (sel == 3) begin
            obs_data = data_w16;
            obs_last = last_w16;
            obs_sum  = sum_w16;
            obs_rx   = {3'b000, rx_w16};
        end else begin
            obs_data = {8'h00, data_b[sel]};
            obs_last = {8'h00, last_b[sel]};
            obs_sum  = {8'h00, sum_b[sel]};
            obs_rx   = {1'b0, rx_b[sel]};
        end
    end

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_total++;
        assert (o === e) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s (inst %0d, cycle %0d): observed %0h expected %0h", tag, sel, cur_c, o, e);
        end
    endtask

    function automatic logic [31:0] word(input int sv, input int st, input int j, input logic [31:0] mask);
        return (sv + j * st) & mask;
    endfunction

    // One burst on the selected instance, started in the current (cycle 0) slot.
    // p1/p2: cycles carrying extra start pulses; rst_at: cycle with rst low (-1 = none).
    task automatic run_burst(input int p1, input int p2, input int rst_at);
        int d, n, w, sv, p, t_done, last_c, k, r, rx;
        logic [31:0] mask, sum, exp_req, exp_ack;
        logic        prev_req;
        logic [15:0] prev_data;
        d  = cfg_d[sel];
        n  = cfg_n[sel];
        w  = cfg_w[sel];
        sv = cfg_sv[sel];
        p      = 4 + d;
        t_done = p * n + 1;
        last_c = (rst_at >= 0) ? rst_at + 3 : t_done + 2;
        mask   = (32'd1 << w) - 32'd1;
        start_v[sel] = 1'b1;
        prev_req  = obs_req;
        prev_data = obs_data;
        for (int c = 1; c <= last_c; c++) begin
            @(negedge clk);
            cur_c = c;
            start_v[sel] = (c == p1) || (c == p2);
            rst_v[sel]   = !(c == rst_at);
            if (rst_at >= 0 && c > rst_at) begin
                check("rst_busy", obs_busy, 0);
                check("rst_done", obs_done, 0);
                check("rst_req",  obs_req,  0);
                check("rst_ack",  obs_ack,  0);
                check("rst_data", obs_data, 0);
                check("rst_last", obs_last, 0);
                check("rst_sum",  obs_sum,  0);
                check("rst_rx",   obs_rx,   0);
            end else begin
                k = 0;
                if (c < t_done) begin
                    k  = (c - 1) / p;
                    r  = (c - 1) % p;
                    exp_req = (r < 2 + d) ? 1 : 0;
                    exp_ack = (r == 1 + d || r == 2 + d) ? 1 : 0;
                    rx = k + ((r >= 1) ? 1 : 0);
                end else begin
                    exp_req = 0;
                    exp_ack = 0;
                    rx = n;
                end
                sum = 0;
                for (int j = 0; j < rx; j++) sum = sum + word(sv, 1, j, mask);
                sum = sum & mask;
                check("busy", obs_busy, (c <= t_done) ? 1 : 0);
                check("done", obs_done, (c == t_done) ? 1 : 0);
                check("req",  obs_req,  exp_req);
                check("ack",  obs_ack,  exp_ack);
                check("rx_count", obs_rx, rx);
                check("checksum", obs_sum, sum);
                if (c < t_done && exp_req == 1) check("data", obs_data, word(sv, 1, k, mask));
                if (rx > 0) check("last_data", obs_last, word(sv, 1, rx - 1, mask));
            end
            if (prev_req && obs_req) check("data_stable", obs_data, prev_data);
            if (!prev_req && obs_req) check("req_rise_ack_low", obs_ack, 0);
            prev_req  = obs_req;
            prev_data = obs_data;
        end
        start_v[sel] = 1'b0;
        rst_v[sel]   = 1'b1;
    endtask

    initial begin
        int pn, rs, q1, q2;

        // Reset state on every instance.
        rst_v   = '0;
        start_v = '0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            sel = i;
            #1;
            cur_c = 0;
            check("reset_busy", obs_busy, 0);
            check("reset_done", obs_done, 0);
            check("reset_req",  obs_req,  0);
            check("reset_ack",  obs_ack,  0);
            check("reset_data", obs_data, 0);
            check("reset_last", obs_last, 0);
            check("reset_sum",  obs_sum,  0);
            check("reset_rx",   obs_rx,   0);
        end
        rst_v = '1;
        @(negedge clk);

        // Default burst A0..A3.
        sel = 0; #1;
        run_burst(-1, -1, -1);

        // Wrap-around FE,FF,00,01.
        sel = 1; #1;
        run_burst(-1, -1, -1);

        // Slave ack delay of two cycles.
        sel = 2; #1;
        run_burst(-1, -1, -1);

        // Starts during a burst are ignored; a later start restarts the checksum.
        sel = 0; #1;
        run_burst(3, 10, -1);
        @(negedge clk);
        run_burst(-1, -1, -1);

        // Mid-burst reset, then a full burst.
        run_burst(-1, -1, 8);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        run_burst(-1, -1, -1);

        // Single-word 16-bit burst.
        sel = 3; #1;
        run_burst(-1, -1, -1);

        // Randomised bursts: instance, ignored start pulses, reset point and gaps.
        for (int it = 0; it < 8; it++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            sel = $urandom_range(0, 3);
            #1;
            pn = (4 + cfg_d[sel]) * cfg_n[sel];
            if ($urandom_range(0, 2) == 0) begin
                rs = $urandom_range(2, pn);
                run_burst(-1, -1, rs);
            end else begin
                q1 = $urandom_range(2, pn);
                q2 = $urandom_range(2, pn);
                run_burst(q1, q2, -1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
